// File: rtl/matrix_multiply_loader.sv
// Streams X then Y into a matrix multiplier's RAMs, starts it, and drains the result RAM as a stream.
// Optional watchdog on the multiplier handshake is enabled by defining MATRIX_LOADER_TIMEOUT_EN.
module matrix_multiply_loader #(
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned X_ROWS         = 2,
  parameter int unsigned Y_COLS         = 2,
  parameter int unsigned X_COLS_Y_ROWS  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  mm_start,
  output logic [ADDR_WIDTH-1:0] mm_ram_addr,
  output logic                  mm_ram_wen,
  output logic [1:0]            mm_ram_sel,
  output logic [DATA_WIDTH-1:0] mm_ram_data_in,
  input  logic                  mm_busy,
  input  logic [DATA_WIDTH-1:0] mm_ram_data_out,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  timeout_err
);

  localparam int unsigned X_WORDS = X_ROWS * X_COLS_Y_ROWS;
  localparam int unsigned Y_WORDS = X_COLS_Y_ROWS * Y_COLS;
  localparam int unsigned R_WORDS = X_ROWS * Y_COLS;
  localparam logic [ADDR_WIDTH-1:0] X_LAST = ADDR_WIDTH'(X_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] Y_LAST = ADDR_WIDTH'(Y_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] R_LAST = ADDR_WIDTH'(R_WORDS - 1);

  localparam logic [1:0] SEL_X = 2'd0;
  localparam logic [1:0] SEL_Y = 2'd1;
  localparam logic [1:0] SEL_R = 2'd2;

  // Matrices must fit the RAM address space and the watchdog needs a nonzero limit.
  if ((X_WORDS > (1 << ADDR_WIDTH)) || (Y_WORDS > (1 << ADDR_WIDTH)) ||
      (R_WORDS > (1 << ADDR_WIDTH)) || (TIMEOUT_CYCLES < 1)) begin : g_bad_cfg
    $error("matrix_multiply_loader: invalid parameter combination");
  end

  typedef enum logic [3:0] {
    IDLE, LOAD_X, LOAD_Y, START, WAIT_HI, WAIT_LO, RD_ADDR, RD_WAIT, OUT, ERR
  } state_t;

  state_t                 state, state_next;
  logic [ADDR_WIDTH-1:0]  index, index_next;
  logic                   s_ready_next, mm_start_next, wen_next, m_valid_next, m_last_next;
  logic [ADDR_WIDTH-1:0]  addr_next;
  logic [1:0]             sel_next;
  logic [DATA_WIDTH-1:0]  data_in_next, m_data_next;
  logic                   accept;
  logic                   timeout_hit;

  assign accept = s_valid && s_ready;

`ifdef MATRIX_LOADER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             in_wait;

  assign in_wait     = (state == WAIT_HI) || (state == WAIT_LO);
  assign timeout_hit = in_wait && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Counts cycles spent waiting on the multiplier; cleared whenever outside the wait states.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      wait_cnt    <= in_wait ? wait_cnt + CNT_W'(1) : '0;
      timeout_err <= (state_next == ERR);
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // State, index and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      index          <= '0;
      s_ready        <= 1'b0;
      mm_start       <= 1'b0;
      mm_ram_addr    <= '0;
      mm_ram_wen     <= 1'b0;
      mm_ram_sel     <= 2'd0;
      mm_ram_data_in <= '0;
      m_data         <= '0;
      m_valid        <= 1'b0;
      m_last         <= 1'b0;
    end else begin
      state          <= state_next;
      index          <= index_next;
      s_ready        <= s_ready_next;
      mm_start       <= mm_start_next;
      mm_ram_addr    <= addr_next;
      mm_ram_wen     <= wen_next;
      mm_ram_sel     <= sel_next;
      mm_ram_data_in <= data_in_next;
      m_data         <= m_data_next;
      m_valid        <= m_valid_next;
      m_last         <= m_last_next;
    end
  end

  // Next-state and next-output logic; outputs appear one cycle after the decision.
  always_comb begin
    state_next    = state;
    index_next    = index;
    mm_start_next = 1'b0;
    wen_next      = 1'b0;
    addr_next     = mm_ram_addr;
    sel_next      = mm_ram_sel;
    data_in_next  = mm_ram_data_in;
    m_data_next   = m_data;
    m_valid_next  = m_valid;
    m_last_next   = m_last;

    case (state)
      IDLE: begin
        if (go) begin
          state_next = LOAD_X;
          index_next = '0;
        end
      end
      LOAD_X: begin
        if (accept) begin
          wen_next     = 1'b1;
          addr_next    = index;
          sel_next     = SEL_X;
          data_in_next = s_data;
          if (index == X_LAST) begin
            index_next = '0;
            state_next = LOAD_Y;
          end else begin
            index_next = index + ADDR_WIDTH'(1);
          end
        end
      end
      LOAD_Y: begin
        if (accept) begin
          wen_next     = 1'b1;
          addr_next    = index;
          sel_next     = SEL_Y;
          data_in_next = s_data;
          if (index == Y_LAST) begin
            index_next = '0;
            state_next = START;
          end else begin
            index_next = index + ADDR_WIDTH'(1);
          end
        end
      end
      // The final write is on the RAM port during this cycle; the start pulse follows it.
      START: begin
        mm_start_next = 1'b1;
        state_next    = WAIT_HI;
      end
      WAIT_HI: begin
        if (mm_busy)          state_next = WAIT_LO;
        else if (timeout_hit) state_next = ERR;
      end
      WAIT_LO: begin
        if (!mm_busy) begin
          state_next = RD_ADDR;
          index_next = '0;
          addr_next  = '0;
          sel_next   = SEL_R;
        end else if (timeout_hit) begin
          state_next = ERR;
        end
      end
      RD_ADDR: state_next = RD_WAIT;
      RD_WAIT: begin
        m_data_next  = mm_ram_data_out;
        m_valid_next = 1'b1;
        m_last_next  = (index == R_LAST);
        state_next   = OUT;
      end
      OUT: begin
        if (m_ready) begin
          m_valid_next = 1'b0;
          m_last_next  = 1'b0;
          if (m_last) begin
            state_next = IDLE;
            index_next = '0;
          end else begin
            index_next = index + ADDR_WIDTH'(1);
            addr_next  = index + ADDR_WIDTH'(1);
            sel_next   = SEL_R;
            state_next = RD_ADDR;
          end
        end
      end
      ERR:     state_next = ERR;
      default: state_next = IDLE;
    endcase

    s_ready_next = (state_next == LOAD_X) || (state_next == LOAD_Y);
  end

endmodule
